// File: rtl/sprite_bank_reader.sv
// sprite_bank_reader: unified sprite pixel RAM, per-sprite palette and
// descriptor tables behind a 3-stage valid/ready read pipeline.
module sprite_bank_reader #(
    parameter int NUM_SPRITES = 8,
    parameter int ADDR_W      = 15,
    parameter int OFF_W       = 14,
    parameter int INDEX_W     = 6,
    parameter int COLOR_W     = 12,
    parameter int TRANSP_IDX  = 0,
    localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SEL_W-1:0]   req_sprite,
    input  logic [OFF_W-1:0]   req_offset,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COLOR_W-1:0] out_color,
    output logic               out_transparent,
    output logic               out_err,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_target,
    input  logic [15:0]        cfg_addr,
    input  logic [15:0]        cfg_data
);

    localparam int PAL_W = SEL_W + INDEX_W;
    localparam logic [SEL_W:0] SPR_LIM = NUM_SPRITES[SEL_W:0];
    localparam logic [INDEX_W-1:0] T_IDX = TRANSP_IDX[INDEX_W-1:0];

    // Storage arrays; contents survive reset.
    logic [INDEX_W-1:0] pix_mem [2**ADDR_W];
    logic [COLOR_W-1:0] pal_mem [2**PAL_W];

    // Descriptor tables.
    logic [ADDR_W-1:0] base_q [NUM_SPRITES];
    logic [ADDR_W-1:0] base_d [NUM_SPRITES];
    logic [OFF_W:0]    size_q [NUM_SPRITES];
    logic [OFF_W:0]    size_d [NUM_SPRITES];

    // S1: decoded request.
    logic              s1_valid_q, s1_valid_d;
    logic [SEL_W-1:0]  s1_sprite_q, s1_sprite_d;
    logic              s1_err_q, s1_err_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;

    // S2: pixel index.
    logic               s2_valid_q, s2_valid_d;
    logic [SEL_W-1:0]   s2_sprite_q, s2_sprite_d;
    logic               s2_err_q, s2_err_d;
    logic [INDEX_W-1:0] s2_idx_q, s2_idx_d;

    // S3: registered outputs.
    logic               out_valid_q, out_valid_d;
    logic [COLOR_W-1:0] out_color_q, out_color_d;
    logic               out_transp_q, out_transp_d;
    logic               out_err_q, out_err_d;

    logic               stall;
    logic               adv;
    logic               spr_ok;
    logic               off_bad;
    logic [SEL_W:0]     req_spr_ext;
    logic [SEL_W:0]     cfg_spr_ext;
    logic [SEL_W-1:0]   cfg_sel;
    logic [INDEX_W-1:0] pix_rd;
    logic [COLOR_W-1:0] pal_rd;
    logic               unused_cfg;

    assign unused_cfg = ^{cfg_addr, cfg_data};

    assign stall     = out_valid_q & ~out_ready;
    assign adv       = ~stall;
    assign req_ready = adv;

    assign out_valid       = out_valid_q;
    assign out_color       = out_color_q;
    assign out_transparent = out_transp_q;
    assign out_err         = out_err_q;

    // Table updates from the config port; visible to the next accept.
    always_comb begin
        base_d      = base_q;
        size_d      = size_q;
        cfg_sel     = cfg_addr[SEL_W-1:0];
        cfg_spr_ext = {1'b0, cfg_sel};
        if (cfg_we && (cfg_spr_ext < SPR_LIM)) begin
            if (cfg_target == 2'd2) begin
                base_d[cfg_sel] = cfg_data[ADDR_W-1:0];
            end else if (cfg_target == 2'd3) begin
                size_d[cfg_sel] = cfg_data[OFF_W:0];
            end
        end
    end

    // Descriptor table registers, cleared so every read errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                base_q[i] <= '0;
                size_q[i] <= '0;
            end
        end else begin
            base_q <= base_d;
            size_q <= size_d;
        end
    end

    // Pixel and palette writes; reads are combinational on the
    // pre-edge contents, so a same-cycle write returns old data.
    always_ff @(posedge clk) begin
        if (cfg_we && cfg_target == 2'd0) begin
            pix_mem[cfg_addr[ADDR_W-1:0]] <= cfg_data[INDEX_W-1:0];
        end
        if (cfg_we && cfg_target == 2'd1) begin
            pal_mem[cfg_addr[PAL_W-1:0]] <= cfg_data[COLOR_W-1:0];
        end
    end

    // Pipeline next-state: everything holds on stall, else shifts.
    always_comb begin
        req_spr_ext = {1'b0, req_sprite};
        spr_ok      = req_spr_ext < SPR_LIM;
        off_bad     = {1'b0, req_offset} >= size_q[req_sprite];
        pix_rd      = pix_mem[s1_addr_q];
        pal_rd      = pal_mem[{s2_sprite_q, s2_idx_q}];

        s1_valid_d   = s1_valid_q;
        s1_sprite_d  = s1_sprite_q;
        s1_err_d     = s1_err_q;
        s1_addr_d    = s1_addr_q;
        s2_valid_d   = s2_valid_q;
        s2_sprite_d  = s2_sprite_q;
        s2_err_d     = s2_err_q;
        s2_idx_d     = s2_idx_q;
        out_valid_d  = out_valid_q;
        out_color_d  = out_color_q;
        out_transp_d = out_transp_q;
        out_err_d    = out_err_q;

        if (adv) begin
            s1_valid_d  = req_valid;
            s1_sprite_d = req_sprite;
            s1_err_d    = ~spr_ok | off_bad;
            s1_addr_d   = base_q[req_sprite] + ADDR_W'(req_offset);

            s2_valid_d  = s1_valid_q;
            s2_sprite_d = s1_sprite_q;
            s2_err_d    = s1_err_q;
            s2_idx_d    = pix_rd;

            out_valid_d = s2_valid_q;
            if (s2_err_q) begin
                out_color_d  = '0;
                out_transp_d = 1'b1;
                out_err_d    = 1'b1;
            end else if (s2_idx_q == T_IDX) begin
                out_color_d  = '0;
                out_transp_d = 1'b1;
                out_err_d    = 1'b0;
            end else begin
                out_color_d  = pal_rd;
                out_transp_d = 1'b0;
                out_err_d    = 1'b0;
            end
        end
    end

    // Pipeline registers; reset drops anything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q   <= 1'b0;
            s1_sprite_q  <= '0;
            s1_err_q     <= 1'b0;
            s1_addr_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_sprite_q  <= '0;
            s2_err_q     <= 1'b0;
            s2_idx_q     <= '0;
            out_valid_q  <= 1'b0;
            out_color_q  <= '0;
            out_transp_q <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sprite_q  <= s1_sprite_d;
            s1_err_q     <= s1_err_d;
            s1_addr_q    <= s1_addr_d;
            s2_valid_q   <= s2_valid_d;
            s2_sprite_q  <= s2_sprite_d;
            s2_err_q     <= s2_err_d;
            s2_idx_q     <= s2_idx_d;
            out_valid_q  <= out_valid_d;
            out_color_q  <= out_color_d;
            out_transp_q <= out_transp_d;
            out_err_q    <= out_err_d;
        end
    end

endmodule

// File: tb/tb_sprite_bank_reader.sv
// tb_sprite_bank_reader: directed checks of config, read pipeline,
// transparency, errors, streaming, backpressure and reset.
module tb_sprite_bank_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_sprite = '0;
    logic [13:0] req_offset = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_color;
    logic        out_transparent;
    logic        out_err;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_target = '0;
    logic [15:0] cfg_addr = '0;
    logic [15:0] cfg_data = '0;

    int checks = 0;
    int failures = 0;

    sprite_bank_reader dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_sprite      (req_sprite),
        .req_offset      (req_offset),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_color       (out_color),
        .out_transparent (out_transparent),
        .out_err         (out_err),
        .cfg_we          (cfg_we),
        .cfg_target      (cfg_target),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cfg_wr(input logic [1:0] t, input int a, input int d);
        cfg_we = 1'b1;
        cfg_target = t;
        cfg_addr = a[15:0];
        cfg_data = d[15:0];
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] s,
                      input int o, input logic [11:0] ec,
                      input logic et, input logic ee);
        int n;
        out_ready = 1'b1;
        req_valid = 1'b1;
        req_sprite = s;
        req_offset = o[13:0];
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, 3);
        chk({tag, "_color"}, out_color, ec);
        chk({tag, "_transp"}, out_transparent, et);
        chk({tag, "_err"}, out_err, ee);
    endtask

    task automatic stream(input string tag, input bit bp);
        int sent, recv, first_acc, first_rx, last_rx;
        bit prev_stall;
        logic [11:0] hold_c;
        logic [11:0] exp_c;
        logic [3:0] pat;
        pat = 4'b1001;
        sent = 0;
        recv = 0;
        first_acc = -1;
        first_rx = -1;
        last_rx = -1;
        prev_stall = 0;
        hold_c = '0;
        for (int cyc = 0; cyc < 200 && recv < 20; cyc++) begin
            out_ready = bp ? pat[cyc % 4] : 1'b1;
            req_valid = (sent < 20);
            req_sprite = 3'd1;
            req_offset = sent[13:0];
            #1;
            if (prev_stall) begin
                chk({tag, "_hold_v"}, out_valid, 1);
                chk({tag, "_hold_c"}, out_color, hold_c);
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) begin
                chk({tag, "_rdy_lo"}, req_ready, 0);
                hold_c = out_color;
            end
            if (out_valid && out_ready) begin
                exp_c = 12'h100 + 12'(recv + 1);
                chk({tag, "_color"}, out_color, exp_c);
                chk({tag, "_err"}, out_err, 0);
                if (first_rx < 0) first_rx = cyc;
                last_rx = cyc;
                recv++;
            end
            if (req_valid && req_ready) begin
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_count"}, recv, 20);
        if (!bp) begin
            chk({tag, "_lat"}, first_rx - first_acc, 3);
            chk({tag, "_gap"}, last_rx - first_rx, 19);
        end
    endtask

    initial begin
        int seen;
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_color", out_color, 0);
        chk("rst_err", out_err, 0);
        chk("rst_transp", out_transparent, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        rd("unconf", 3'd1, 5, 12'h000, 1'b1, 1'b1);

        // Sprite 1 load and basic read.
        cfg_wr(2'd2, 1, 100);
        cfg_wr(2'd3, 1, 625);
        cfg_wr(2'd0, 105, 3);
        cfg_wr(2'd1, 64 + 3, 'hF00);
        rd("basic", 3'd1, 5, 12'hF00, 1'b0, 1'b0);

        // Transparency and bounds.
        cfg_wr(2'd0, 100, 0);
        rd("transp", 3'd1, 0, 12'h000, 1'b1, 1'b0);
        rd("oob", 3'd1, 625, 12'h000, 1'b1, 1'b1);
        cfg_wr(2'd0, 724, 5);
        cfg_wr(2'd1, 64 + 5, 'hABC);
        rd("last", 3'd1, 624, 12'hABC, 1'b0, 1'b0);
        rd("spr0", 3'd0, 0, 12'h000, 1'b1, 1'b1);

        // Stream data: offset i -> index i+1 -> colour 0x100+i+1.
        for (int i = 0; i < 20; i++) begin
            cfg_wr(2'd0, 100 + i, i + 1);
            cfg_wr(2'd1, 64 + i + 1, 'h100 + i + 1);
        end
        stream("strm", 1'b0);
        stream("bp", 1'b1);

        // Read-first on pixel RAM.
        cfg_wr(2'd0, 105, 3);
        cfg_wr(2'd1, 64 + 3, 'hF00);
        cfg_wr(2'd1, 64 + 7, 'h0F7);
        out_ready = 1'b1;
        req_valid = 1'b1;
        req_sprite = 3'd1;
        req_offset = 14'd5;
        @(negedge clk);
        req_valid = 1'b0;
        cfg_we = 1'b1;
        cfg_target = 2'd0;
        cfg_addr = 16'd105;
        cfg_data = 16'd7;
        @(negedge clk);
        cfg_we = 1'b0;
        @(negedge clk);
        chk("rf_old_v", out_valid, 1);
        chk("rf_old_c", out_color, 12'hF00);
        rd("rf_new", 3'd1, 5, 12'h0F7, 1'b0, 1'b0);

        // Reset mid-stream.
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_sprite = 3'd1;
            req_offset = 14'(i);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("mid_pre_v", out_valid, 1);
        reset = 1'b0;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_err", out_err, 0);
        chk("mid_color", out_color, 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid_quiet", seen, 0);
        rd("mid_after", 3'd1, 5, 12'h000, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
